// File: rtl/aes_link_pkg.sv
// aes_link_pkg: state encoding and sizing shared by the AES host link
package aes_link_pkg;
    typedef enum logic [3:0] {IDLE = 4'd0, RX_KEY = 4'd1, RX_MSG = 4'd2, WAIT = 4'd3, TX = 4'd4} state_t;
    localparam int MSG_BITS = 128;
    function automatic int words(input int bits, input int w);
        return bits / w;
    endfunction
endpackage

// File: rtl/aes_link_if.sv
// aes_link_if: half-duplex pad bus between host pads and the link controller
interface aes_link_if #(parameter int BUS_W = 8);
    logic [BUS_W-1:0] pad_i, pad_o;
    logic stb_i, key_keep, pad_oe, stb_o;
    modport master (output pad_i, stb_i, key_keep, input pad_o, pad_oe, stb_o);
    modport slave (input pad_i, stb_i, key_keep, output pad_o, pad_oe, stb_o);
endinterface

// File: rtl/link_sync_edge.sv
// link_sync_edge: 2-flop synchronizer with registered one-cycle rising-edge pulse
module link_sync_edge (
    input  logic CLK,
    input  logic Reset,
    input  logic sig,
    output logic rise
);
    logic [2:0] sync;
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            sync <= '0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[1:0], sig};
            rise <= sync[1] & ~sync[2];
        end
    end
endmodule

// File: rtl/aes_link_ctrl.sv
// aes_link_ctrl: byte-serial host link collecting key/plaintext and returning AES ciphertext
module aes_link_ctrl import aes_link_pkg::*; #(
    parameter int BUS_W    = 8,
    parameter int KEY_BITS = 256,
    parameter int AES_LAT  = 1,
    parameter int SETUP    = 4,
    parameter int STB_CYC  = 4,
    parameter int TIMEOUT  = 2**20
) (
    input  logic                CLK,
    input  logic                Reset,
    aes_link_if.slave           bus,
    output logic [MSG_BITS-1:0] aes_msg,
    output logic [KEY_BITS-1:0] aes_key,
    input  logic [MSG_BITS-1:0] aes_out,
    output logic                err,
    output logic [15:0]         led
);
    localparam int KEY_WORDS = words(KEY_BITS, BUS_W);
    localparam int MSG_WORDS = words(MSG_BITS, BUS_W);
    localparam int CW = $clog2(TIMEOUT + SETUP + STB_CYC + AES_LAT + 1);
    state_t state;
    logic [7:0] word_cnt, last_word;
    logic [CW-1:0] cnt;
    logic [MSG_BITS-1:0] tx_sh;
    logic rx_pulse;
    link_sync_edge u_sync (.CLK(CLK), .Reset(Reset), .sig(bus.stb_i), .rise(rx_pulse));
    // Shifting zeros in behind the ciphertext leaves pad_o at 0 once the frame is out
    assign bus.pad_o = tx_sh[MSG_BITS-1 -: BUS_W];
    assign led = {state, err, 3'b000, word_cnt};
    assign last_word = (state == RX_KEY) ? 8'(KEY_WORDS - 1) : 8'(MSG_WORDS - 1);
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            word_cnt   <= '0;
            cnt        <= '0;
            tx_sh      <= '0;
            aes_msg    <= '0;
            aes_key    <= '0;
            err        <= 1'b0;
            bus.pad_oe <= 1'b0;
            bus.stb_o  <= 1'b0;
        end else begin
            if (rx_pulse && state inside {WAIT, TX}) err <= 1'b1;
            case (state)
                IDLE: if (rx_pulse) begin
                    err      <= 1'b0;
                    word_cnt <= 8'd1;
                    cnt      <= '0;
                    if (bus.key_keep) begin
                        aes_msg <= {aes_msg[MSG_BITS-BUS_W-1:0], bus.pad_i};
                        state   <= RX_MSG;
                    end else begin
                        aes_key <= {aes_key[KEY_BITS-BUS_W-1:0], bus.pad_i};
                        state   <= RX_KEY;
                    end
                end
                RX_KEY, RX_MSG: if (rx_pulse) begin
                    cnt <= '0;
                    if (state == RX_KEY) aes_key <= {aes_key[KEY_BITS-BUS_W-1:0], bus.pad_i};
                    else aes_msg <= {aes_msg[MSG_BITS-BUS_W-1:0], bus.pad_i};
                    if (word_cnt == last_word) begin
                        word_cnt <= '0;
                        state    <= (state == RX_KEY) ? RX_MSG : WAIT;
                    end else word_cnt <= word_cnt + 8'd1;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    err      <= 1'b1;
                    word_cnt <= '0;
                    state    <= IDLE;
                end else cnt <= cnt + 1'b1;
                // One extra cycle past AES_LAT so the core output has settled before capture
                WAIT: if (cnt == CW'(AES_LAT)) begin
                    tx_sh      <= aes_out;
                    bus.pad_oe <= 1'b1;
                    cnt        <= '0;
                    word_cnt   <= '0;
                    state      <= TX;
                end else cnt <= cnt + 1'b1;
                TX: begin
                    if (cnt == CW'(SETUP - 1)) bus.stb_o <= 1'b1;
                    if (cnt == CW'(SETUP + STB_CYC - 1)) begin
                        bus.stb_o <= 1'b0;
                        cnt       <= '0;
                        tx_sh     <= tx_sh << BUS_W;
                        if (word_cnt == 8'(MSG_WORDS - 1)) begin
                            word_cnt   <= '0;
                            bus.pad_oe <= 1'b0;
                            state      <= IDLE;
                        end else word_cnt <= word_cnt + 8'd1;
                    end else cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_link_ctrl.sv
// tb_aes_link_ctrl: directed frame vectors plus timeout, TX-collision, reset and 16-bit bus sequences
module tb_aes_link_ctrl;
    import aes_link_pkg::*;
    localparam int TO = 200;
    localparam int SETUP = 4;
    localparam int STB_CYC = 4;
    localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] K3 = {8{32'hdeadbeef}};
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] P2 = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] C1 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic CLK = 1'b0, Reset = 1'b1;
    always #5 CLK = ~CLK;

    aes_link_if #(8) b8();
    aes_link_if #(16) b16();
    logic [127:0] msg8, out8 = '0, msg16, out16 = '0, key16;
    logic [255:0] key8;
    logic err8, err16;
    logic [15:0] led8, led16;

    aes_link_ctrl #(.BUS_W(8), .KEY_BITS(256), .AES_LAT(1), .SETUP(SETUP), .STB_CYC(STB_CYC), .TIMEOUT(TO)) d8 (
        .CLK(CLK), .Reset(Reset), .bus(b8), .aes_msg(msg8), .aes_key(key8),
        .aes_out(out8), .err(err8), .led(led8));
    aes_link_ctrl #(.BUS_W(16), .KEY_BITS(128), .AES_LAT(1), .SETUP(SETUP), .STB_CYC(STB_CYC), .TIMEOUT(TO)) d16 (
        .CLK(CLK), .Reset(Reset), .bus(b16), .aes_msg(msg16), .aes_key(key16),
        .aes_out(out16), .err(err16), .led(led16));

    // Core stand-in: known FIPS-197 vectors, otherwise a cheap invertible mix, one cycle latency
    always @(posedge CLK) out8 <= (key8 == K1 && msg8 == P1) ? C1 : ~msg8 ^ key8[127:0];
    always @(posedge CLK) out16 <= (key16 == K2 && msg16 == P1) ? C2 : ~msg16;

    int pass_n = 0, tot_n = 0;
    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        tot_n++;
        if (got === exp) pass_n++;
        else $display("FAIL %s: got %0h want %0h", name, got, exp);
    endtask

    task automatic send_word(input logic [7:0] w);
        b8.pad_i = w;
        @(negedge CLK) b8.stb_i = 1'b1;
        repeat (6) @(negedge CLK);
        b8.stb_i = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic send_frame(input logic keep, input logic [255:0] key, input logic [127:0] pt,
                              input int first, input int last);
        int nk;
        nk = keep ? 0 : 32;
        b8.key_keep = keep;
        for (int i = first; i < last; i++)
            send_word(i < nk ? key[255 - 8*i -: 8] : pt[127 - 8*(i - nk) -: 8]);
    endtask

    // Collects 16 TX words, counting every cycle whose pad_oe/stb_o/pad_o breaks the word timing
    task automatic recv8(output logic [127:0] got, output int bad);
        int t;
        got = '0;
        bad = 0;
        t = 0;
        while (!b8.pad_oe && t < 3000) begin
            @(negedge CLK);
            t++;
        end
        if (!b8.pad_oe) begin
            bad = 999;
            return;
        end
        for (int w = 0; w < 16; w++) begin
            for (int c = 0; c < SETUP; c++) begin
                if (b8.stb_o || !b8.pad_oe) bad++;
                @(negedge CLK);
            end
            got = {got[119:0], b8.pad_o};
            for (int c = 0; c < STB_CYC; c++) begin
                if (!b8.stb_o || !b8.pad_oe || b8.pad_o != got[7:0]) bad++;
                @(negedge CLK);
            end
        end
        if (b8.pad_oe || b8.stb_o) bad++;
    endtask

    task automatic send16(input logic [15:0] w);
        b16.pad_i = w;
        @(negedge CLK) b16.stb_i = 1'b1;
        repeat (6) @(negedge CLK);
        b16.stb_i = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    typedef struct {
        logic keep;
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        logic [255:0] key_after;
    } vec_t;
    vec_t tbl[4];

    initial begin
        logic [127:0] got;
        int bad, t;
        tbl[0] = '{1'b0, K1, P1, C1, K1};
        tbl[1] = '{1'b1, '0, P2, ~P2 ^ K1[127:0], K1};
        tbl[2] = '{1'b1, '0, P1, C1, K1};
        tbl[3] = '{1'b0, K3, P2, ~P2 ^ K3[127:0], K3};
        b8.pad_i = '0; b8.stb_i = 1'b0; b8.key_keep = 1'b0;
        b16.pad_i = '0; b16.stb_i = 1'b0; b16.key_keep = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_led", led8, 16'h0000);
        chk("rst_pad_o", b8.pad_o, 8'h00);
        chk("rst_pad_oe", b8.pad_oe, 1'b0);
        chk("rst_stb_o", b8.stb_o, 1'b0);
        chk("rst_msg", msg8, '0);
        chk("rst_key", key8, '0);
        chk("rst_err", err8, 1'b0);
        chk("rst_led16", led16, 16'h0000);
        Reset = 1'b0;
        repeat (3) @(negedge CLK);

        for (int v = 0; v < 4; v++) begin
            fork
                send_frame(tbl[v].keep, tbl[v].key, tbl[v].pt, 0, tbl[v].keep ? 16 : 48);
                recv8(got, bad);
            join
            chk($sformatf("v%0d_ct", v), got, tbl[v].ct);
            chk($sformatf("v%0d_timing", v), bad, 0);
            chk($sformatf("v%0d_key", v), key8, tbl[v].key_after);
            chk($sformatf("v%0d_msg", v), msg8, tbl[v].pt);
            chk($sformatf("v%0d_led", v), led8, 16'h0000);
            chk($sformatf("v%0d_pad_oe", v), b8.pad_oe, 1'b0);
        end

        send_frame(1'b0, K1, P1, 0, 10);
        chk("to_partial", led8, 16'h100a);
        repeat (TO / 2) @(negedge CLK);
        chk("to_not_yet", led8, 16'h100a);
        repeat (TO) @(negedge CLK);
        chk("to_led", led8, 16'h0800);
        chk("to_err", err8, 1'b1);
        chk("to_pad_oe", b8.pad_oe, 1'b0);
        chk("to_key_kept", key8, {K3[175:0], K1[255:176]});
        send_word(K1[255:248]);
        chk("to_err_clr", led8, 16'h1001);

        fork
            send_frame(1'b0, K1, P1, 1, 48);
            recv8(got, bad);
            begin
                t = 0;
                while (!b8.pad_oe && t < 3000) begin
                    @(negedge CLK);
                    t++;
                end
                repeat (20) @(negedge CLK);
                for (int k = 0; k < 3; k++) begin
                    b8.stb_i = 1'b1;
                    repeat (5) @(negedge CLK);
                    b8.stb_i = 1'b0;
                    repeat (5) @(negedge CLK);
                end
            end
        join
        chk("col_ct", got, C1);
        chk("col_timing", bad, 0);
        chk("col_err", err8, 1'b1);
        chk("col_led", led8, 16'h0800);

        fork
            send_frame(1'b0, K1, P1, 0, 48);
            begin
                int w;
                w = 0;
                while (!(b8.pad_oe && b8.stb_o && led8[7:0] == 8'd4) && w < 3000) begin
                    @(negedge CLK);
                    w++;
                end
                chk("rst_tx_reached", led8[15:12], 4'd4);
                Reset = 1'b1;
                #1;
                chk("rst_tx_pad_oe", b8.pad_oe, 1'b0);
                chk("rst_tx_stb_o", b8.stb_o, 1'b0);
                chk("rst_tx_led", led8, 16'h0000);
                chk("rst_tx_key", key8, '0);
            end
        join
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
        repeat (3) @(negedge CLK);

        fork
            for (int i = 0; i < 16; i++)
                send16(i < 8 ? K2[127 - 16*i -: 16] : P1[127 - 16*(i - 8) -: 16]);
            begin
                got = '0;
                for (int w = 0; w < 8; w++) begin
                    int t1;
                    t1 = 0;
                    while (!b16.stb_o && t1 < 3000) begin
                        @(negedge CLK);
                        t1++;
                    end
                    got = {got[111:0], b16.pad_o};
                    t1 = 0;
                    while (b16.stb_o && t1 < 100) begin
                        @(negedge CLK);
                        t1++;
                    end
                end
            end
        join
        repeat (2) @(negedge CLK);
        chk("w16_ct", got, C2);
        chk("w16_key", key16, K2);
        chk("w16_pad_oe", b16.pad_oe, 1'b0);
        chk("w16_led", led16, 16'h0000);

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
